// File: rtl/mux_sequencer.sv
// mux_sequencer: steps the input-mux front end (U402/U414/U413, U902, precharge)
// through a programmed table with break-before-make gaps, dwell and sample strobe.
module mux_sequencer #(
    parameter int NUM_STEPS  = 8,
    parameter int BBM_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    output logic        busy,
    output logic [2:0]  step,
    output logic        sample_strobe,
    output logic        done,
    output logic        U402_EN_CTL,
    output logic        U414_EN_CTL,
    output logic        U413_EN_CTL,
    output logic [2:0]  U402_A_CTL,
    output logic [2:0]  U414_A_CTL,
    output logic [2:0]  U413_A_CTL,
    output logic [3:0]  U902_SW_CTL,
    output logic        SIG_PC_SW_CTL,
    output logic        _4094_OE_CTL
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_BREAK  = 2'd1;
    localparam logic [1:0]  ST_DWELL  = 2'd2;
    localparam logic [13:0] BBM_LOAD  = 14'(BBM_CYCLES - 1);
    localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);

    logic [31:0] tbl [8];
    logic [1:0]  state, nxt_state;
    logic [13:0] cnt, nxt_cnt;
    logic [2:0]  nxt_step;
    logic [31:0] work, nxt_work;
    logic        load, nxt_done, terminal, drive_addr, drive_en;

    always_ff @(posedge CLK) begin
        if (cfg_we && (int'(cfg_addr) < NUM_STEPS))
            tbl[cfg_addr] <= cfg_data;
    end

    assign terminal = work[17] || (step == LAST_STEP);

    // cnt counts down the remaining cycles of the current BREAK or DWELL phase
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_step  = step;
        nxt_done  = 1'b0;
        load      = 1'b0;
        if (stop) begin
            nxt_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        nxt_state = ST_BREAK;
                        nxt_step  = '0;
                        nxt_cnt   = BBM_LOAD;
                        load      = 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (cnt == '0) begin
                        nxt_state = ST_DWELL;
                        nxt_cnt   = (work[31:18] == '0) ? '0 : work[31:18] - 14'd1;
                    end else begin
                        nxt_cnt = cnt - 14'd1;
                    end
                end
                ST_DWELL: begin
                    if (cnt != '0) begin
                        nxt_cnt = cnt - 14'd1;
                    end else if (!terminal) begin
                        nxt_state = ST_BREAK;
                        nxt_step  = step + 3'd1;
                        nxt_cnt   = BBM_LOAD;
                        load      = 1'b1;
                    end else if (loop) begin
                        nxt_state = ST_BREAK;
                        nxt_step  = '0;
                        nxt_cnt   = BBM_LOAD;
                        load      = 1'b1;
                    end else begin
                        nxt_state = ST_IDLE;
                        nxt_done  = 1'b1;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
        end
        nxt_work   = load ? tbl[nxt_step] : work;
        drive_addr = (nxt_state != ST_IDLE);
        drive_en   = (nxt_state == ST_DWELL);
    end

    // Outputs are registered from the next-state values so they line up with state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            work          <= '0;
            busy          <= 1'b0;
            step          <= '0;
            sample_strobe <= 1'b0;
            done          <= 1'b0;
            U402_EN_CTL   <= 1'b0;
            U414_EN_CTL   <= 1'b0;
            U413_EN_CTL   <= 1'b0;
            U402_A_CTL    <= '0;
            U414_A_CTL    <= '0;
            U413_A_CTL    <= '0;
            U902_SW_CTL   <= '0;
            SIG_PC_SW_CTL <= 1'b0;
            _4094_OE_CTL  <= 1'b0;
        end else begin
            state         <= nxt_state;
            cnt           <= nxt_cnt;
            work          <= nxt_work;
            busy          <= drive_addr;
            step          <= nxt_step;
            sample_strobe <= drive_en && (nxt_cnt == '0);
            done          <= nxt_done;
            U402_EN_CTL   <= drive_en && nxt_work[3];
            U414_EN_CTL   <= drive_en && nxt_work[7];
            U413_EN_CTL   <= drive_en && nxt_work[11];
            U402_A_CTL    <= drive_addr ? nxt_work[2:0]  : 3'd0;
            U414_A_CTL    <= drive_addr ? nxt_work[6:4]  : 3'd0;
            U413_A_CTL    <= drive_addr ? nxt_work[10:8] : 3'd0;
            U902_SW_CTL   <= drive_en ? nxt_work[15:12] : 4'd0;
            SIG_PC_SW_CTL <= drive_en && nxt_work[16];
            _4094_OE_CTL  <= 1'b1;
        end
    end
endmodule
